// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router controller: FSM encodings, port count,
// invalid-address code and the default receiver idle timeout.
package router_pkg;

   localparam int NUM_PORTS       = 3;
   localparam int DEFAULT_TIMEOUT = 30;

   localparam logic [1:0] ADDR_INVALID = 2'b11;

   typedef logic [2:0] state_t;

   localparam state_t DECODE     = 3'd0;
   localparam state_t WAIT_EMPTY = 3'd1;
   localparam state_t LFD        = 3'd2;
   localparam state_t LOAD       = 3'd3;
   localparam state_t CHECK      = 3'd4;
   localparam state_t DROP       = 3'd5;

   // Address 3 selects no port, so it maps to an all-zero mask.
   function automatic logic [NUM_PORTS-1:0] portOneHot(input logic [1:0] addr);
      logic [NUM_PORTS-1:0] w_oneHot;
      w_oneHot = '0;
      if (addr != ADDR_INVALID) begin
         w_oneHot[addr] = 1'b1;
      end
      return w_oneHot;
   endfunction

endpackage

// File: rtl/router_timeout.sv
// Per-port receiver idle counter: pulses a one-cycle soft reset after TIMEOUT
// consecutive cycles of valid data that nobody reads.
module router_timeout
   import router_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
)
(
   input  logic clock,
   input  logic resetn,
   input  logic i_vld,
   input  logic i_readEnb,
   output logic o_softReset
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] r_count;
   logic          r_pulse;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_count <= '0;
         r_pulse <= 1'b0;
      end else if (i_vld && !i_readEnb) begin
         if (r_count == CW'(TIMEOUT - 1)) begin
            r_count <= '0;
            r_pulse <= 1'b1;
         end else begin
            r_count <= r_count + 1'b1;
            r_pulse <= 1'b0;
         end
      end else begin
         r_count <= '0;
         r_pulse <= 1'b0;
      end
   end

   assign o_softReset = r_pulse;

endmodule

// File: rtl/router_ctrl.sv
// Packet-level controller of the 1x3 router: header decode, FIFO write
// sequencing through a one-entry hold register, parity/length checking.
module router_ctrl
   import router_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
)
(
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 pkt_valid,
   input  logic [7:0]           data_in,
   input  logic [NUM_PORTS-1:0] fifo_full,
   input  logic [NUM_PORTS-1:0] fifo_empty,
   input  logic [NUM_PORTS-1:0] read_enb,
   output logic [7:0]           fifo_din,
   output logic [NUM_PORTS-1:0] fifo_wr_enb,
   output logic                 lfd_state,
   output logic [NUM_PORTS-1:0] soft_reset,
   output logic [NUM_PORTS-1:0] vld_out,
   output logic                 busy,
   output logic                 err
);

   state_t               r_state;
   logic [1:0]           r_addr;
   logic [5:0]           r_len;
   logic [5:0]           r_count;
   logic                 r_lenOvf;
   logic [7:0]           r_parity;
   logic [7:0]           r_hold;
   logic                 r_holdValid;
   logic                 r_holdIsParity;
   logic                 r_err;

   logic [NUM_PORTS-1:0] w_addrOneHot;
   logic                 w_portFull;
   logic                 w_portEmpty;
   logic                 w_portSoftReset;
   logic                 w_accept;
   logic                 w_wrFire;
   logic                 w_midAbort;
   logic                 w_lastTaken;
   logic                 w_chkErr;

   assign w_addrOneHot    = portOneHot(r_addr);
   assign w_portFull      = |(w_addrOneHot & fifo_full);
   assign w_portEmpty     = |(w_addrOneHot & fifo_empty);
   assign w_portSoftReset = |(w_addrOneHot & soft_reset);

   assign busy = (r_state == WAIT_EMPTY) || (r_state == LFD) || (r_state == CHECK) ||
                 (r_holdValid && w_portFull);

   // Once the parity byte sits in the hold, LOAD takes nothing more; the next
   // header belongs to DECODE.
   assign w_accept = !busy && (((r_state == DECODE) && pkt_valid) ||
                               ((r_state == LOAD) && !r_holdIsParity) ||
                               (r_state == DROP));

   assign w_wrFire    = r_holdValid && !w_portFull && !w_portSoftReset;
   assign fifo_wr_enb = w_wrFire ? w_addrOneHot : '0;
   assign fifo_din    = r_hold;
   assign lfd_state   = (r_state == LFD);
   assign vld_out     = ~fifo_empty;
   assign err         = r_err;

   assign w_midAbort  = w_portSoftReset &&
                        ((r_state == WAIT_EMPTY) || (r_state == LFD) || (r_state == LOAD));
   assign w_lastTaken = (r_state == LOAD) && (r_holdIsParity || (w_accept && !pkt_valid));
   assign w_chkErr    = (r_hold != r_parity) || (r_count != r_len) || r_lenOvf;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state        <= DECODE;
         r_addr         <= 2'b00;
         r_len          <= '0;
         r_count        <= '0;
         r_lenOvf       <= 1'b0;
         r_parity       <= '0;
         r_hold         <= '0;
         r_holdValid    <= 1'b0;
         r_holdIsParity <= 1'b0;
         r_err          <= 1'b0;
      end else begin
         r_err <= 1'b0;
         // A receiver timeout kills the packet; if its parity byte is already
         // in, there is nothing left to drop and the error is flagged at once.
         if (w_midAbort) begin
            r_holdValid    <= 1'b0;
            r_holdIsParity <= 1'b0;
            if (w_lastTaken) begin
               r_state <= DECODE;
               r_err   <= 1'b1;
            end else begin
               r_state <= DROP;
            end
         end else begin
            case (r_state)
               DECODE: begin
                  if (w_accept) begin
                     r_addr   <= data_in[1:0];
                     r_len    <= data_in[7:2];
                     r_parity <= data_in;
                     r_count  <= '0;
                     r_lenOvf <= 1'b0;
                     r_hold   <= data_in;
                     if (data_in[1:0] == ADDR_INVALID) begin
                        r_state <= DROP;
                     end else if (|(portOneHot(data_in[1:0]) & fifo_empty)) begin
                        r_state <= LFD;
                     end else begin
                        r_state <= WAIT_EMPTY;
                     end
                  end
               end
               WAIT_EMPTY: begin
                  if (w_portEmpty) begin
                     r_state <= LFD;
                  end
               end
               LFD: begin
                  r_holdValid    <= 1'b1;
                  r_holdIsParity <= 1'b0;
                  r_state        <= LOAD;
               end
               LOAD: begin
                  if (w_accept) begin
                     r_hold         <= data_in;
                     r_holdValid    <= 1'b1;
                     r_holdIsParity <= !pkt_valid;
                     if (pkt_valid) begin
                        r_parity <= r_parity ^ data_in;
                        if (r_count == 6'd63) begin
                           r_lenOvf <= 1'b1;
                        end else begin
                           r_count <= r_count + 6'd1;
                        end
                     end
                  end else if (w_wrFire) begin
                     r_holdValid <= 1'b0;
                     if (r_holdIsParity) begin
                        r_holdIsParity <= 1'b0;
                        r_state        <= CHECK;
                        r_err          <= w_chkErr;
                     end
                  end
               end
               CHECK: begin
                  r_state <= DECODE;
               end
               DROP: begin
                  if (w_accept && !pkt_valid) begin
                     r_state <= DECODE;
                     r_err   <= 1'b1;
                  end
               end
               default: begin
                  r_state <= DECODE;
               end
            endcase
         end
      end
   end

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_timeout
      router_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
         .clock       (clock),
         .resetn      (resetn),
         .i_vld       (vld_out[p]),
         .i_readEnb   (read_enb[p]),
         .o_softReset (soft_reset[p])
      );
   end

endmodule

// File: tb/tb_router_ctrl.sv
// Self-checking bench for router_ctrl: a scoreboard of expected FIFO writes is
// filled as packets are driven and drained as the controller writes.
module tb_router_ctrl;

   logic       clock = 1'b0;
   logic       resetn;
   logic       pkt_valid;
   logic [7:0] data_in;
   logic [2:0] fifo_full;
   logic [2:0] fifo_empty;
   logic [2:0] read_enb;
   logic [7:0] fifo_din;
   logic [2:0] fifo_wr_enb;
   logic       lfd_state;
   logic [2:0] soft_reset;
   logic [2:0] vld_out;
   logic       busy;
   logic       err;

   logic [10:0] sbQ[$];
   logic [7:0]  payQ[$];
   logic [10:0] sbExp;

   int numChecks = 0;
   int numPassed = 0;
   int errCount  = 0;
   int busyCount = 0;
   int wrCount   = 0;
   int errMark, busyMark, wrMark;
   int lfdWait, stallBusy, pulseCount, firstPulse, otherPulses;

   always #5 clock = ~clock;

   router_ctrl #(.TIMEOUT(30)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .pkt_valid   (pkt_valid),
      .data_in     (data_in),
      .fifo_full   (fifo_full),
      .fifo_empty  (fifo_empty),
      .read_enb    (read_enb),
      .fifo_din    (fifo_din),
      .fifo_wr_enb (fifo_wr_enb),
      .lfd_state   (lfd_state),
      .soft_reset  (soft_reset),
      .vld_out     (vld_out),
      .busy        (busy),
      .err         (err)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      numChecks++;
      if (observed === expected) begin
         numPassed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one byte and hold it until the controller takes it on a non-busy edge.
   task automatic applyStimulus(input logic [7:0] b, input logic v);
      int waitCycles;
      data_in    = b;
      pkt_valid  = v;
      waitCycles = 0;
      @(negedge clock);
      while (busy && waitCycles < 200) begin
         @(negedge clock);
         waitCycles++;
      end
      if (busy) begin
         checkOutput("acceptTimeout", busy, 0);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic sendPacket(input logic [7:0] hdr, input logic badParity);
      logic [7:0] par;
      logic [2:0] oneHot;
      oneHot = 3'b001 << hdr[1:0];
      par    = hdr;
      if (hdr[1:0] != 2'b11) sbQ.push_back({oneHot, hdr});
      applyStimulus(hdr, 1'b1);
      foreach (payQ[i]) begin
         par ^= payQ[i];
         if (hdr[1:0] != 2'b11) sbQ.push_back({oneHot, payQ[i]});
         applyStimulus(payQ[i], 1'b1);
      end
      if (badParity) par = ~par;
      if (hdr[1:0] != 2'b11) sbQ.push_back({oneHot, par});
      applyStimulus(par, 1'b0);
      pkt_valid = 1'b0;
      data_in   = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   always @(negedge clock) begin
      if (resetn) begin
         if (err)  errCount++;
         if (busy) busyCount++;
         if (fifo_wr_enb != 3'b000) begin
            wrCount++;
            checkOutput("wrOneHot", $onehot(fifo_wr_enb), 1);
            checkOutput("wrToFull", fifo_wr_enb & fifo_full, 0);
            checkOutput("sbPending", sbQ.size() != 0, 1);
            if (sbQ.size() != 0) begin
               sbExp = sbQ.pop_front();
               checkOutput("sbWrite", {fifo_wr_enb, fifo_din}, sbExp);
            end
         end
      end
   end

   initial begin
      resetn     = 1'b0;
      pkt_valid  = 1'b0;
      data_in    = 8'h00;
      fifo_full  = 3'b000;
      fifo_empty = 3'b101;
      read_enb   = 3'b111;
      #12;
      checkOutput("rstWrEnb", fifo_wr_enb, 0);
      checkOutput("rstDin", fifo_din, 0);
      checkOutput("rstLfd", lfd_state, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstErr", err, 0);
      checkOutput("rstSoftReset", soft_reset, 0);
      checkOutput("rstVldOut", vld_out, 3'b010);
      fifo_empty = 3'b111;
      @(posedge clock);
      #1 resetn = 1'b1;
      idle(2);

      // Basic packet to port 1
      payQ = '{8'h11, 8'h22, 8'h33};
      errMark = errCount; busyMark = busyCount;
      fork
         sendPacket(8'h0D, 1'b0);
         begin
            lfdWait = 0;
            while (!lfd_state && lfdWait < 20) begin
               @(negedge clock);
               lfdWait++;
            end
            checkOutput("lfdCycle", lfdWait, 2);
            checkOutput("lfdNoWrite", fifo_wr_enb, 0);
            for (int i = 0; i < 5; i++) begin
               @(negedge clock);
               checkOutput("basicWrEnb", fifo_wr_enb, 3'b010);
               if (i == 0) checkOutput("lfdOneCycle", lfd_state, 0);
            end
            @(negedge clock);
            checkOutput("basicWrEnd", fifo_wr_enb, 0);
         end
      join
      idle(3);
      checkOutput("basicErr", errCount - errMark, 0);
      checkOutput("basicBusy", busyCount - busyMark, 2);

      // Full stall mid-payload to port 0
      payQ.delete();
      for (int i = 0; i < 6; i++) payQ.push_back(8'($urandom));
      errMark = errCount; busyMark = busyCount;
      fork
         sendPacket(8'h18, 1'b0);
         begin
            repeat (5) @(posedge clock);
            #1 fifo_full[0] = 1'b1;
            stallBusy = 0;
            for (int i = 0; i < 4; i++) begin
               @(negedge clock);
               if (busy) stallBusy++;
            end
            @(posedge clock);
            #1 fifo_full[0] = 1'b0;
            @(negedge clock);
            checkOutput("stallBusyAfter", busy, 0);
            checkOutput("stallBusyCycles", stallBusy, 4);
         end
      join
      idle(3);
      checkOutput("stallErr", errCount - errMark, 0);
      checkOutput("stallBusyTotal", busyCount - busyMark, 6);

      // Header to port 2 while its FIFO still drains
      fifo_empty[2] = 1'b0;
      payQ = '{8'hC3, 8'h96};
      errMark = errCount;
      fork
         sendPacket(8'h0A, 1'b0);
         begin
            repeat (2) @(negedge clock);
            checkOutput("waitBusy", busy, 1);
            checkOutput("waitNoLfd", lfd_state, 0);
            stallBusy = 0;
            for (int i = 0; i < 3; i++) begin
               @(negedge clock);
               if (busy) stallBusy++;
            end
            checkOutput("waitBusyHeld", stallBusy, 3);
            @(posedge clock);
            #1 fifo_empty[2] = 1'b1;
            @(negedge clock);
            checkOutput("waitLfdNotYet", lfd_state, 0);
            @(negedge clock);
            checkOutput("waitLfdNext", lfd_state, 1);
         end
      join
      idle(3);
      checkOutput("waitErr", errCount - errMark, 0);

      // Wrong parity byte
      payQ = '{8'hA5, 8'h5A, 8'h3C};
      errMark = errCount;
      sendPacket(8'h0D, 1'b1);
      idle(4);
      checkOutput("parityErr", errCount - errMark, 1);

      // Header length 4 with only 3 payload bytes
      payQ = '{8'h01, 8'h02, 8'h04};
      errMark = errCount;
      sendPacket(8'h11, 1'b0);
      idle(4);
      checkOutput("lengthErr", errCount - errMark, 1);

      // Invalid address is dropped
      payQ = '{8'h77, 8'h88};
      errMark = errCount; busyMark = busyCount; wrMark = wrCount;
      sendPacket(8'h0B, 1'b0);
      idle(4);
      checkOutput("dropErr", errCount - errMark, 1);
      checkOutput("dropBusy", busyCount - busyMark, 0);
      checkOutput("dropWrites", wrCount - wrMark, 0);

      // Receiver on port 0 stops reading
      fifo_empty[0] = 1'b0;
      read_enb[0]   = 1'b0;
      #0;
      checkOutput("toVld", vld_out[0], 1);
      pulseCount = 0; firstPulse = 0; otherPulses = 0;
      for (int k = 1; k <= 35; k++) begin
         @(posedge clock);
         #1;
         if (soft_reset[0]) begin
            pulseCount++;
            if (firstPulse == 0) firstPulse = k;
         end
         if (soft_reset[2:1] != 2'b00) otherPulses++;
      end
      checkOutput("toFirstPulse", firstPulse, 30);
      checkOutput("toPulseCount", pulseCount, 1);
      checkOutput("toOtherPorts", otherPulses, 0);
      fifo_empty[0] = 1'b1;
      read_enb[0]   = 1'b1;
      idle(2);

      // Asynchronous reset in the middle of a packet
      sbQ.push_back({3'b010, 8'h0D});
      applyStimulus(8'h0D, 1'b1);
      applyStimulus(8'h44, 1'b1);
      fifo_full[1] = 1'b1;
      #1;
      checkOutput("preRstBusy", busy, 1);
      checkOutput("preRstDin", fifo_din, 8'h44);
      #1 resetn = 1'b0;
      #1;
      checkOutput("midRstWrEnb", fifo_wr_enb, 0);
      checkOutput("midRstDin", fifo_din, 0);
      checkOutput("midRstLfd", lfd_state, 0);
      checkOutput("midRstBusy", busy, 0);
      checkOutput("midRstErr", err, 0);
      checkOutput("midRstSoftReset", soft_reset, 0);
      pkt_valid = 1'b0;
      data_in   = 8'h00;
      fifo_full = 3'b000;
      @(posedge clock);
      #1 resetn = 1'b1;
      checkOutput("midRstSbDrained", sbQ.size(), 0);
      idle(2);

      // Clean packet after reset recovery
      payQ = '{8'h5E, 8'hE5};
      errMark = errCount;
      sendPacket(8'h08, 1'b0);
      idle(4);
      checkOutput("recoverErr", errCount - errMark, 0);
      checkOutput("sbDrained", sbQ.size(), 0);

      $display("%0d/%0d checks passed", numPassed, numChecks);
      $finish;
   end

endmodule
